signature_uart_tx: RTL and testbench

Downstream consumer of the serial signature ROM stage. The ROM presents one bit on q, MSB first, and advances on en. This block pulls bits from it with ld/en, packs each 8 bits into a byte, and transmits the byte as 8N1 UART on a single output pin. One start request sends the whole NUM_BYTES message, then the block returns to idle.

---
 rtl/signature_uart_tx_if.sv | 30 +++
 rtl/signature_uart_tx.sv | 120 ++++++++++++
 tb/tb_signature_uart_tx.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/signature_uart_tx_if.sv
// Signature-to-UART link: start request, serial ROM bit stream with its ld/en strobes, and UART line status.
interface signature_uart_tx_if;
    logic start;
    logic sig_q;
    logic sig_ld;
    logic sig_en;
    logic tx;
    logic busy;
    logic done;

    modport slave (
        input  start,
        input  sig_q,
        output sig_ld,
        output sig_en,
        output tx,
        output busy,
        output done
    );

    modport master (
        output start,
        output sig_q,
        input  sig_ld,
        input  sig_en,
        input  tx,
        input  busy,
        input  done
    );
endinterface

// File: rtl/signature_uart_tx.sv
// Pulls a NUM_BYTES signature bit-serially from the ROM stage (MSB first) and sends it as 8N1 UART.
// One start = one whole message; ld once per message, 8 en strobes per byte, no LOAD between bytes.
module signature_uart_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int NUM_BYTES    = 40
) (
    input  logic               clk,
    input  logic               reset,
    signature_uart_tx_if.slave bus
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]        BYTE_LAST = 8'(NUM_BYTES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    logic [2:0]        r_state;
    logic [7:0]        r_shift;
    logic [2:0]        r_bit_cnt;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [7:0]        r_byte_cnt;
    logic              r_tx;
    logic              r_done;

    logic              w_baud_end;
    logic [2:0]        w_bit_nxt;

    assign w_baud_end = (r_baud_cnt == BAUD_LAST);
    assign w_bit_nxt  = r_bit_cnt + 3'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= 8'd0;
            r_bit_cnt  <= 3'd0;
            r_baud_cnt <= '0;
            r_byte_cnt <= 8'd0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx       <= 1'b1;
                    r_byte_cnt <= 8'd0;
                    if (bus.start) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_bit_cnt <= 3'd0;
                    r_state   <= S_FETCH;
                end
                S_FETCH: begin
                    // ROM advances on this same edge, so q is taken while en is high
                    r_shift   <= {r_shift[6:0], bus.sig_q};
                    r_bit_cnt <= w_bit_nxt;
                    if (r_bit_cnt == 3'd7) begin
                        r_state    <= S_START;
                        r_tx       <= 1'b0;
                        r_baud_cnt <= '0;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= 3'd0;
                        r_tx       <= r_shift[0];
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_cnt == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit_cnt <= w_bit_nxt;
                            r_tx      <= r_shift[w_bit_nxt];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud_cnt <= '0;
                        if (r_byte_cnt == BYTE_LAST) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 8'd1;
                            r_bit_cnt  <= 3'd0;
                            r_state    <= S_FETCH;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sig_ld = (r_state == S_LOAD);
    assign bus.sig_en = (r_state == S_FETCH);
    assign bus.busy   = (r_state != S_IDLE);
    assign bus.tx     = r_tx;
    assign bus.done   = r_done;
endmodule

// File: tb/tb_signature_uart_tx.sv
// Bench for signature_uart_tx: two instances (4 clk/bit x 40 bytes, 2 clk/bit x 1 byte), each fed by a serial ROM model.
module tb_signature_uart_tx;
    localparam int CPB_A = 4;
    localparam int NB_A  = 40;
    localparam int CPB_B = 2;
    localparam int NB_B  = 1;
    localparam int LEN_A = 1 + NB_A * (8 + 10 * CPB_A);
    localparam int LEN_B = 1 + NB_B * (8 + 10 * CPB_B);

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    signature_uart_tx_if if_a ();
    signature_uart_tx_if if_b ();

    signature_uart_tx #(.CLKS_PER_BIT(CPB_A), .NUM_BYTES(NB_A)) u_dut_a (
        .clk(clk), .reset(reset), .bus(if_a)
    );
    signature_uart_tx #(.CLKS_PER_BIT(CPB_B), .NUM_BYTES(NB_B)) u_dut_b (
        .clk(clk), .reset(reset), .bus(if_b)
    );

    always #5 clk = ~clk;

    // 320-bit signature ROM content, shared by both ROM models
    logic [7:0] msg [40];
    initial begin
        msg[0] = 8'h4C; msg[1] = 8'h75; msg[2] = 8'h6B; msg[3] = 8'h65;
        for (int i = 4; i < 38; i++) msg[i] = 8'h61 + 8'((i - 4) % 26);
        msg[38] = 8'h0D; msg[39] = 8'h0A;
    end

    logic [8:0] ptr_a = 9'd0;
    logic [8:0] ptr_b = 9'd0;
    always @(posedge clk) begin
        if (if_a.sig_ld) ptr_a <= 9'd0;
        else if (if_a.sig_en) ptr_a <= (ptr_a == 9'd319) ? 9'd0 : ptr_a + 9'd1;
        if (if_b.sig_ld) ptr_b <= 9'd0;
        else if (if_b.sig_en) ptr_b <= (ptr_b == 9'd319) ? 9'd0 : ptr_b + 9'd1;
    end
    assign if_a.sig_q = msg[ptr_a[8:3]][~ptr_a[2:0]];
    assign if_b.sig_q = msg[ptr_b[8:3]][~ptr_b[2:0]];

    // Expected {ld,en,busy,done,tx} at offset o cycles after the LOAD cycle of an active message
    function automatic logic [4:0] expect_at(int o, int c, int nb, bit act);
        int per, b, r, k;
        logic t;
        per = 8 + 10 * c;
        if (!act || o < 0 || o > 1 + nb * per) return 5'b00001;
        if (o == 1 + nb * per) return 5'b00011;
        if (o == 0) return 5'b10101;
        b = (o - 1) / per;
        r = (o - 1) % per;
        if (r < 8) return 5'b01101;
        k = (r - 8) / c;
        if (k == 0) t = 1'b0;
        else if (k == 9) t = 1'b1;
        else t = msg[b][k-1];
        return {4'b0010, t};
    endfunction

    // Model: track when each instance accepts start and where its LOAD cycle falls
    bit act_a = 0, act_b = 0;
    int L_a = 0, L_b = 0;
    always @(posedge clk) begin
        if (reset) begin
            act_a = 0;
            act_b = 0;
        end else begin
            if (if_a.start && !(act_a && cyc >= L_a && cyc < L_a + LEN_A)) begin
                act_a = 1; L_a = cyc + 1;
            end
            if (if_b.start && !(act_b && cyc >= L_b && cyc < L_b + LEN_B)) begin
                act_b = 1; L_b = cyc + 1;
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        logic [4:0] ea, eb, ga, gb;
        ea = reset ? 5'b00001 : expect_at(cyc - L_a, CPB_A, NB_A, act_a);
        eb = reset ? 5'b00001 : expect_at(cyc - L_b, CPB_B, NB_B, act_b);
        ga = {if_a.sig_ld, if_a.sig_en, if_a.busy, if_a.done, if_a.tx};
        gb = {if_b.sig_ld, if_b.sig_en, if_b.busy, if_b.done, if_b.tx};
        n_checks++;
        if (ga !== ea) begin
            n_fail++;
            $display("FAIL cycle_a @%0d: {ld,en,busy,done,tx} got %b expected %b", cyc, ga, ea);
        end
        n_checks++;
        if (gb !== eb) begin
            n_fail++;
            $display("FAIL cycle_b @%0d: {ld,en,busy,done,tx} got %b expected %b", cyc, gb, eb);
        end
    end

    // Event watchers and a UART receiver on instance A
    int ld_cnt_a = 0, done_cnt_a = 0, last_ld_a = 0, last_done_a = 0;
    int ld_cnt_b = 0, en_cnt_b = 0, done_cnt_b = 0, last_ld_b = 0, last_done_b = 0, fall_b = -1;
    logic prev_tx_b = 1'b1;
    logic [7:0] rx_q [$];
    bit   rx_on = 0;
    int   rx_t = 0;
    logic [7:0] rx_byte = 8'd0;
    logic prev_tx_a = 1'b1;
    always @(negedge clk) begin
        if (reset) begin
            rx_on = 0;
            prev_tx_a = 1'b1;
            prev_tx_b = 1'b1;
        end else begin
            if (if_a.sig_ld) begin ld_cnt_a++; last_ld_a = cyc; end
            if (if_a.done) begin done_cnt_a++; last_done_a = cyc; end
            if (if_b.sig_ld) begin ld_cnt_b++; last_ld_b = cyc; end
            if (if_b.sig_en) en_cnt_b++;
            if (if_b.done) begin done_cnt_b++; last_done_b = cyc; end
            if (prev_tx_b && !if_b.tx && fall_b < 0) fall_b = cyc;
            prev_tx_b = if_b.tx;
            if (!rx_on && prev_tx_a && !if_a.tx) begin
                rx_on = 1; rx_t = 0;
            end else if (rx_on) begin
                rx_t++;
                if (rx_t % CPB_A == CPB_A / 2) begin
                    if (rx_t / CPB_A >= 1 && rx_t / CPB_A <= 8) rx_byte[rx_t / CPB_A - 1] = if_a.tx;
                    else if (rx_t / CPB_A == 9) begin
                        rx_q.push_back(rx_byte);
                        rx_on = 0;
                    end
                end
            end
            prev_tx_a = if_a.tx;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done_a(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt_a < target && n < budget) begin step(); n++; end
        if (done_cnt_a < target) chk({name, "_timeout"}, done_cnt_a, target);
    endtask

    task automatic check_msg(input int base, input string name);
        int bad = 0;
        for (int i = 0; i < NB_A; i++)
            if (base + i >= rx_q.size() || rx_q[base + i] != msg[i]) bad++;
        chk(name, bad, 0);
    endtask

    initial begin
        int ld0, dn0, d1;
        if_a.start = 1'b0;
        if_b.start = 1'b0;
        reset = 1'b1;
        repeat (3) step();
        chk("reset_tx_a", int'(if_a.tx), 1);
        chk("reset_busy_a", int'(if_a.busy), 0);
        chk("reset_ld_en_a", int'({if_a.sig_ld, if_a.sig_en}), 0);
        reset = 1'b0;
        repeat (2) step();

        // Single byte at 2 clk/bit: strobe counts and frame timing
        if_b.start = 1'b1; step(); if_b.start = 1'b0;
        for (int n = 0; n < 200 && done_cnt_b == 0; n++) step();
        chk("b_done_count", done_cnt_b, 1);
        chk("b_ld_count", ld_cnt_b, 1);
        chk("b_en_count", en_cnt_b, 8);
        chk("b_txfall_after_ld", fall_b - last_ld_b, 9);
        chk("b_frame_len", last_done_b - fall_b, 20);
        chk("b_done_after_ld", last_done_b - last_ld_b, 29);

        // Full 40-byte message, with a start pulse injected during byte 5
        ld0 = ld_cnt_a; dn0 = done_cnt_a;
        if_a.start = 1'b1; step(); if_a.start = 1'b0;
        for (int n = 0; n < 400 && cyc < last_ld_a + 1 + 5 * 48 + 20; n++) step();
        if_a.start = 1'b1; step(); if_a.start = 1'b0;
        wait_done_a(dn0 + 1, 2500, "a_msg");
        repeat (5) step();
        chk("a_rx_count", rx_q.size(), 40);
        if (rx_q.size() >= 40) begin
            chk("a_byte0_L", rx_q[0], 8'h4C);
            chk("a_byte1_u", rx_q[1], 8'h75);
            chk("a_byte2_k", rx_q[2], 8'h6B);
            chk("a_byte3_e", rx_q[3], 8'h65);
            chk("a_byte38_cr", rx_q[38], 8'h0D);
            chk("a_byte39_lf", rx_q[39], 8'h0A);
        end
        check_msg(0, "a_bytes_vs_rom");
        chk("a_ld_once", ld_cnt_a - ld0, 1);
        chk("a_done_once", done_cnt_a - dn0, 1);
        chk("a_done_after_ld", last_done_a - last_ld_a, LEN_A);

        // start held high: two messages back to back, then release
        rx_q.delete();
        ld0 = ld_cnt_a; dn0 = done_cnt_a;
        if_a.start = 1'b1;
        wait_done_a(dn0 + 1, 2500, "b2b_first");
        d1 = last_done_a;
        wait_done_a(dn0 + 2, 2500, "b2b_second");
        if_a.start = 1'b0;
        repeat (10) step();
        chk("b2b_reload_gap", last_ld_a - d1, 1);
        chk("b2b_ld_count", ld_cnt_a - ld0, 2);
        chk("b2b_rx_count", rx_q.size(), 80);
        check_msg(0, "b2b_msg1");
        check_msg(40, "b2b_msg2");

        // Reset in the middle of a data bit, then a clean message
        if_a.start = 1'b1; step(); if_a.start = 1'b0;
        for (int n = 0; n < 100 && cyc < last_ld_a + 1 + 8 + 4 * 3 + 1; n++) step();
        chk("pre_reset_busy", int'(if_a.busy), 1);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_tx", int'(if_a.tx), 1);
        chk("rst_mid_busy", int'(if_a.busy), 0);
        chk("rst_mid_en", int'(if_a.sig_en), 0);
        chk("rst_mid_done", int'(if_a.done), 0);
        repeat (3) step();
        #1 reset = 1'b0;
        repeat (3) step();
        rx_q.delete();
        ld0 = ld_cnt_a; dn0 = done_cnt_a;
        if_a.start = 1'b1; step(); if_a.start = 1'b0;
        wait_done_a(dn0 + 1, 2500, "post_reset");
        repeat (5) step();
        chk("post_reset_ld", ld_cnt_a - ld0, 1);
        chk("post_reset_rx_count", rx_q.size(), 40);
        check_msg(0, "post_reset_bytes");
        chk("post_reset_len", last_done_a - last_ld_a, LEN_A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
